noop_pipe: RTL and testbench

// - Parametrised successor to the plain particle-word passthrough: carries WIDTH-bit words
//   (default 105, one particle record) from producer to consumer through DEPTH registered

---
 rtl/md_pkg.sv | 21 ++
 rtl/noop_skid_slice.sv | 82 ++++++++
 rtl/noop_pipe.sv | 89 ++++++++
 tb/tb_noop_pipe.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types for the particle pipelines: record width, particle word type, skid-slice states.
package md_pkg;

  localparam int PARTICLE_W = 105;

  typedef logic [PARTICLE_W-1:0] particle_t;

  typedef enum logic [1:0] {
    SLICE_EMPTY = 2'd0,
    SLICE_ONE   = 2'd1,
    SLICE_TWO   = 2'd2
  } slice_state_t;

  // Occupancy counter width: enough for 0..2*depth, never narrower than one bit.
  function automatic int occ_width(input int depth);
    int w;
    w = $clog2(2 * depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/noop_skid_slice.sv
// One two-entry valid/ready skid slice (main + skid register) with synchronous flush.
module noop_skid_slice
  import md_pkg::*;
#(
  parameter int WIDTH = PARTICLE_W
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_up_valid,
  output logic             o_up_ready,
  input  logic [WIDTH-1:0] i_up_data,
  output logic             o_dn_valid,
  input  logic             i_dn_ready,
  output logic [WIDTH-1:0] o_dn_data
);

  slice_state_t     r_state;
  logic             r_up_ready;
  logic             r_dn_valid;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_push;
  logic             w_pop;

  assign w_push     = i_up_valid && r_up_ready;
  assign w_pop      = r_dn_valid && i_dn_ready;
  assign o_up_ready = r_up_ready;
  assign o_dn_valid = r_dn_valid;
  assign o_dn_data  = r_main;

  // Occupancy FSM; ready and valid are registered next to the state they decode.
  always_ff @(posedge clk) begin
    if (!i_rst_n || i_flush) begin
      r_state    <= SLICE_EMPTY;
      r_up_ready <= 1'b1;
      r_dn_valid <= 1'b0;
    end else begin
      case (r_state)
        SLICE_EMPTY: begin
          if (w_push) begin
            r_state    <= SLICE_ONE;
            r_dn_valid <= 1'b1;
          end
        end
        SLICE_ONE: begin
          if (w_push && !w_pop) begin
            r_state    <= SLICE_TWO;
            r_up_ready <= 1'b0;
          end else if (!w_push && w_pop) begin
            r_state    <= SLICE_EMPTY;
            r_dn_valid <= 1'b0;
          end
        end
        SLICE_TWO: begin
          if (w_pop) begin
            r_state    <= SLICE_ONE;
            r_up_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= SLICE_EMPTY;
          r_up_ready <= 1'b1;
          r_dn_valid <= 1'b0;
        end
      endcase
    end
  end

  // Payload registers are not reset; the FSM alone says which of them hold live words.
  always_ff @(posedge clk) begin
    if (w_push && (!r_dn_valid || w_pop)) begin
      r_main <= i_up_data;
    end else if (w_pop && !r_up_ready) begin
      r_main <= r_skid;
    end
    if (w_push && r_dn_valid && !w_pop) begin
      r_skid <= i_up_data;
    end
  end

endmodule

// File: rtl/noop_pipe.sv
// Parametrised particle-word passthrough built from DEPTH skid slices (DEPTH=0 is a plain wire).
// Define NOOP_PIPE_STATS_EN to add the occ / stall_cnt observation ports and counters.
module noop_pipe
  import md_pkg::*;
#(
  parameter  int WIDTH = PARTICLE_W,
  parameter  int DEPTH = 2,
  localparam int OCCW  = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef NOOP_PIPE_STATS_EN
  ,
  output logic [OCCW-1:0]  occ,
  output logic [31:0]      stall_cnt
`endif
);

  if (DEPTH == 0) begin : g_wire
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready;
  end else begin : g_pipe
    logic             w_valid [DEPTH+1];
    logic             w_ready [DEPTH+1];
    logic [WIDTH-1:0] w_data  [DEPTH+1];

    assign w_valid[0]     = in_valid;
    assign w_data[0]      = in_data;
    assign in_ready       = rst_n && !flush && w_ready[0];
    assign w_ready[DEPTH] = out_ready;
    assign out_valid      = w_valid[DEPTH];
    assign out_data       = w_data[DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_slice
      noop_skid_slice #(.WIDTH(WIDTH)) u_slice (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .i_flush    (flush),
        .i_up_valid (w_valid[i]),
        .o_up_ready (w_ready[i]),
        .i_up_data  (w_data[i]),
        .o_dn_valid (w_valid[i+1]),
        .i_dn_ready (w_ready[i+1]),
        .o_dn_data  (w_data[i+1])
      );
    end
  end

`ifdef NOOP_PIPE_STATS_EN
  logic [OCCW-1:0] r_occ;
  logic [31:0]     r_stall;
  logic            w_push;
  logic            w_pop;

  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign occ       = r_occ;
  assign stall_cnt = r_stall;

  // Word count: pushes minus pops, cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_occ <= {OCCW{1'b0}};
    end else if (w_push && !w_pop) begin
      r_occ <= r_occ + {{(OCCW-1){1'b0}}, 1'b1};
    end else if (!w_push && w_pop) begin
      r_occ <= r_occ - {{(OCCW-1){1'b0}}, 1'b1};
    end
  end

  // Saturating stall counter; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall <= 32'd0;
    end else if (out_valid && !out_ready && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noop_pipe.sv
// Scoreboard bench for noop_pipe: DEPTH=2 and DEPTH=3 pipes against a word-queue model,
// plus a DEPTH=0 instance checked as a wire under random stimulus.
`timescale 1ns/1ps
module tb_noop_pipe;
  localparam int W = 105;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic iv [3];
  logic ir [3];
  logic ov [3];
  logic orr [3];
  logic [W-1:0] id [3];
  logic [W-1:0] od [3];
`ifdef NOOP_PIPE_STATS_EN
  logic [2:0]  occ_a [2];
  logic [31:0] st_a [2];
  logic        occ_d0;
  logic [31:0] st_d0;
  logic [31:0] st_before;
  int          mst [3];
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [W-1:0] sbq [2][$];
  int dep [2] = '{2, 3};
  int first_acc [2];
  int first_out [2];
  int last_out [2];
  int out_cnt [2];
  bit have_prev [2];
  bit prev_stall [2];
  logic [W-1:0] prev_od [2];
  bit rst_prev = 1'b0;

  always #5 clk = ~clk;

  noop_pipe #(.WIDTH(W), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od[0])
`ifdef NOOP_PIPE_STATS_EN
    , .occ(occ_a[0]), .stall_cnt(st_a[0])
`endif
  );

  noop_pipe #(.WIDTH(W), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od[1])
`ifdef NOOP_PIPE_STATS_EN
    , .occ(occ_a[1]), .stall_cnt(st_a[1])
`endif
  );

  noop_pipe #(.WIDTH(W), .DEPTH(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od[2])
`ifdef NOOP_PIPE_STATS_EN
    , .occ(occ_d0), .stall_cnt(st_d0)
`endif
  );

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats(input int k);
    first_acc[k] = -1;
    first_out[k] = -1;
    last_out[k]  = -1;
    out_cnt[k]   = 0;
  endtask

  // Monitor: mid-cycle sampling; pops expected words on output transfers, records accepts.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        cmp("rst_in_ready", ir[k], 1'b0);
        if (rst_prev) cmp("rst_out_valid", ov[k], 1'b0);
        sbq[k].delete();
        have_prev[k] = 1'b0;
`ifdef NOOP_PIPE_STATS_EN
        mst[k] = 0;
`endif
      end else begin
`ifdef NOOP_PIPE_STATS_EN
        cmp("occ", occ_a[k], sbq[k].size());
        cmp("stall_cnt", st_a[k], mst[k]);
        if (ov[k] && !orr[k]) mst[k]++;
`endif
        if (sbq[k].size() >= 2 * dep[k]) cmp("full_in_ready", ir[k], 1'b0);
        if (sbq[k].size() == 0) cmp("empty_out_valid", ov[k], 1'b0);
        if (have_prev[k] && prev_stall[k]) begin
          cmp("hold_valid", ov[k], 1'b1);
          cmp("hold_data", od[k], prev_od[k]);
        end
        if (ov[k] && orr[k]) begin
          out_cnt[k]++;
          if (first_out[k] < 0) first_out[k] = cyc;
          last_out[k] = cyc;
          if (sbq[k].size() != 0) cmp("out_data", od[k], sbq[k].pop_front());
        end
        if (flush) begin
          cmp("flush_in_ready", ir[k], 1'b0);
          sbq[k].delete();
        end else if (iv[k] && ir[k]) begin
          if (first_acc[k] < 0) first_acc[k] = cyc;
          sbq[k].push_back(id[k]);
        end
        have_prev[k]  = !flush;
        prev_stall[k] = ov[k] && !orr[k];
        prev_od[k]    = od[k];
      end
    end
    cmp("d0_data", od[2], id[2]);
    cmp("d0_ready", ir[2], orr[2]);
    cmp("d0_valid", ov[2], iv[2]);
`ifdef NOOP_PIPE_STATS_EN
    if (!rst_n) begin
      mst[2] = 0;
    end else begin
      cmp("d0_occ", occ_d0, 1'b0);
      cmp("d0_stall_cnt", st_d0, mst[2]);
      if (iv[2] && !orr[2]) mst[2]++;
    end
`endif
    rst_prev = !rst_n;
  end

  initial begin
    int acc;
    int sent;
    int guard;
    bit a;
    bit b;
    rst_n = 1'b0;
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k]  = 1'b0;
      orr[k] = 1'b0;
      id[k]  = '0;
    end
    clr_stats(0);
    clr_stats(1);
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    cmp("reset_out_valid", ov[0], 1'b0);
    cmp("reset_in_ready", ir[0], 1'b1);
`ifdef NOOP_PIPE_STATS_EN
    cmp("reset_occ", occ_a[0], 3'd0);
    cmp("reset_stall", st_a[0], 32'd0);
`endif

    // Streaming on DEPTH=2.
    tick();
    orr[0] = 1'b1;
    clr_stats(0);
    iv[0] = 1'b1;
    id[0] = '0;
    sent = 0;
    guard = 0;
    while (sent < 1000 && guard < 5000) begin
      @(negedge clk);
      a = ir[0];
      tick();
      guard++;
      if (a) begin
        sent++;
        id[0] = W'(sent);
      end
    end
    iv[0] = 1'b0;
    cmp("stream_sent", sent, 1000);
    repeat (6) tick();
    cmp("stream_latency", first_out[0] - first_acc[0], 2);
    cmp("stream_count", out_cnt[0], 1000);
    cmp("stream_rate", last_out[0] - first_out[0], 999);

    // Back-pressure on DEPTH=2.
    orr[0] = 1'b0;
    iv[0] = 1'b1;
    acc = 0;
    repeat (10) begin
      @(negedge clk);
      a = ir[0];
      tick();
      if (a) begin
        acc++;
        id[0] = id[0] + W'(1);
      end
    end
    iv[0] = 1'b0;
    cmp("bp_accepted", acc, 4);
    @(negedge clk);
    cmp("bp_in_ready", ir[0], 1'b0);
`ifdef NOOP_PIPE_STATS_EN
    cmp("bp_occ", occ_a[0], 3'd4);
`endif
    tick();
    clr_stats(0);
    orr[0] = 1'b1;
    repeat (8) tick();
    cmp("bp_drain_count", out_cnt[0], 4);
    cmp("bp_drain_gap", last_out[0] - first_out[0], 3);

    // Flush with three words held.
    orr[0] = 1'b0;
    iv[0] = 1'b1;
    acc = 0;
    guard = 0;
    while (acc < 3 && guard < 20) begin
      @(negedge clk);
      a = ir[0];
      tick();
      guard++;
      if (a) begin
        acc++;
        id[0] = id[0] + W'(1);
      end
    end
    cmp("flush_fill", acc, 3);
    flush = 1'b1;
    orr[0] = 1'b1;
    @(negedge clk);
    cmp("flush_cycle_in_ready", ir[0], 1'b0);
`ifdef NOOP_PIPE_STATS_EN
    st_before = st_a[0];
`endif
    tick();
    flush = 1'b0;
    iv[0] = 1'b0;
    orr[0] = 1'b0;
    @(negedge clk);
    cmp("flush_out_valid", ov[0], 1'b0);
`ifdef NOOP_PIPE_STATS_EN
    cmp("flush_occ", occ_a[0], 3'd0);
    cmp("flush_stall_kept", st_a[0], st_before);
`endif

    // Reset in the middle of traffic on both pipes.
    tick();
    iv[0] = 1'b1;
    iv[1] = 1'b1;
    repeat (12) begin
      @(negedge clk);
      a = ir[0];
      b = ir[1];
      tick();
      if (a) id[0] = id[0] + W'(1);
      if (b) id[1] = id[1] + W'(1);
      orr[0] = ($urandom_range(0, 3) == 0);
      orr[1] = ($urandom_range(0, 3) == 0);
    end
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    iv[0] = 1'b0;
    iv[1] = 1'b0;
    @(negedge clk);
    cmp("release_in_ready_d2", ir[0], 1'b1);
    cmp("release_in_ready_d3", ir[1], 1'b1);
    cmp("release_out_valid", ov[0], 1'b0);
`ifdef NOOP_PIPE_STATS_EN
    cmp("release_stall_d2", st_a[0], 32'd0);
    cmp("release_stall_d3", st_a[1], 32'd0);
`endif

    // Random traffic on DEPTH=3 and DEPTH=0.
    tick();
    orr[0] = 1'b0;
    sent = 0;
    guard = 0;
    while ((sent < 10000 || sbq[1].size() != 0) && guard < 60000) begin
      @(negedge clk);
      a = iv[1] && ir[1];
      tick();
      guard++;
      if (a) sent++;
      if (!iv[1] || a) begin
        iv[1] = (sent < 10000) && ($urandom_range(0, 1) == 1);
        id[1] = rnd_word();
      end
      orr[1] = ($urandom_range(0, 1) == 1);
      iv[2]  = ($urandom_range(0, 1) == 1);
      orr[2] = ($urandom_range(0, 1) == 1);
      id[2]  = rnd_word();
    end
    cmp("random_sent", sent, 10000);
    cmp("random_drained", sbq[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
